if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line I-cache.
// Hits are served combinationally; misses refill over a registered request/ack bus.
module if_fetch_unit #(
  parameter int pc_size   = 18,
  parameter int data_size = 32,
  parameter int lines     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_stall,
  input  logic                 branch_taken,
  input  logic [pc_size-1:0]   branch_target,
  input  logic                 im_ack,
  input  logic [data_size-1:0] im_rdata,
  output logic [pc_size-1:0]   IF_PC,
  output logic [data_size-1:0] IF_ir,
  output logic                 if_miss_stall,
  output logic                 im_req,
  output logic [pc_size-1:0]   im_addr
);

  localparam int IDX_W = $clog2(lines);
  localparam int TAG_W = pc_size - 2 - IDX_W;
  localparam logic [pc_size-1:0] PC_STEP    = pc_size'(4);
  localparam logic [pc_size-1:0] ALIGN_MASK = ~pc_size'(3);

  typedef enum logic [0:0] {
    S_LOOKUP = 1'b0,
    S_MISS   = 1'b1
  } state_t;

  function automatic logic [pc_size-1:0] word_align(input logic [pc_size-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  state_t                 r_state;
  state_t                 w_next_state;
  logic [pc_size-1:0]     r_pc;
  logic                   r_im_req;
  logic                   r_pend;
  logic [pc_size-1:0]     r_pend_target;
  logic [lines-1:0]       r_valid;
  logic [TAG_W-1:0]       r_tag  [lines];
  logic [data_size-1:0]   r_data [lines];

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_fill;
  logic [pc_size-1:0]     w_branch_pc;
  logic [pc_size-1:0]     w_pc_next;
  logic                   w_pend_next;
  logic [pc_size-1:0]     w_pend_target_next;

  assign w_idx       = r_pc[1+IDX_W:2];
  assign w_tag       = r_pc[pc_size-1:2+IDX_W];
  assign w_branch_pc = word_align(branch_target);
  assign w_hit       = (r_state == S_LOOKUP) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A refill completes only while a request is actually outstanding.
  assign w_fill      = (r_state == S_MISS) && r_im_req && im_ack;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOOKUP;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          w_next_state = S_LOOKUP;
        end else begin
          w_next_state = S_MISS;
        end
      end
      S_MISS: begin
        if (w_fill) begin
          w_next_state = S_LOOKUP;
        end else begin
          w_next_state = S_MISS;
        end
      end
      default: w_next_state = S_LOOKUP;
    endcase
  end

  // FSM outputs: fetch presentation and refill bus
  always_comb begin
    IF_PC   = r_pc;
    im_req  = r_im_req;
    im_addr = word_align(r_pc);
    if (w_hit) begin
      IF_ir         = r_data[w_idx];
      if_miss_stall = 1'b0;
    end else begin
      IF_ir         = {data_size{1'b0}};
      if_miss_stall = 1'b1;
    end
  end

  // Next PC and pending-redirect bookkeeping; redirects seen during a miss apply after refill
  always_comb begin
    w_pc_next          = r_pc;
    w_pend_next        = r_pend;
    w_pend_target_next = r_pend_target;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          if (pc_stall) begin
            w_pc_next = r_pc;
          end else if (branch_taken) begin
            w_pc_next = w_branch_pc;
          end else begin
            w_pc_next = r_pc + PC_STEP;
          end
        end else if (branch_taken) begin
          w_pend_next        = 1'b1;
          w_pend_target_next = w_branch_pc;
        end else begin
          w_pend_next = r_pend;
        end
      end
      S_MISS: begin
        if (w_fill) begin
          w_pend_next = 1'b0;
          if (branch_taken) begin
            w_pc_next = w_branch_pc;
          end else if (r_pend) begin
            w_pc_next = r_pend_target;
          end else begin
            w_pc_next = r_pc;
          end
        end else if (branch_taken) begin
          w_pend_next        = 1'b1;
          w_pend_target_next = w_branch_pc;
        end else begin
          w_pend_next = r_pend;
        end
      end
      default: begin
        w_pc_next   = r_pc;
        w_pend_next = 1'b0;
      end
    endcase
  end

  // PC, request, pending redirect and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= {pc_size{1'b0}};
      r_im_req      <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_target <= {pc_size{1'b0}};
      r_valid       <= {lines{1'b0}};
    end else begin
      r_pc          <= w_pc_next;
      r_im_req      <= (w_next_state == S_MISS);
      r_pend        <= w_pend_next;
      r_pend_target <= w_pend_target_next;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (!rst && w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= im_rdata;
    end
  end

  if_fetch_unit_chk #(
    .pc_size   (pc_size),
    .data_size (data_size)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .im_req        (im_req),
    .im_ack        (im_ack),
    .im_addr       (im_addr),
    .if_miss_stall (if_miss_stall),
    .IF_ir         (IF_ir),
    .IF_PC         (IF_PC)
  );

endmodule

// Interface invariants of the fetch unit, observed from its ports only.
module if_fetch_unit_chk #(
  parameter int pc_size   = 18,
  parameter int data_size = 32
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 im_req,
  input logic                 im_ack,
  input logic [pc_size-1:0]   im_addr,
  input logic                 if_miss_stall,
  input logic [data_size-1:0] IF_ir,
  input logic [pc_size-1:0]   IF_PC
);

  a_req_implies_stall: assert property (@(posedge clk) im_req |-> if_miss_stall);

  a_stall_is_nop: assert property (@(posedge clk) if_miss_stall |-> (IF_ir == {data_size{1'b0}}));

  a_req_held: assert property (@(posedge clk)
    (im_req && !im_ack && !rst) |=> (im_req && $stable(im_addr)));

  a_reset_state: assert property (@(posedge clk)
    rst |=> (!im_req && (IF_PC == {pc_size{1'b0}})));

endmodule
